// File: rtl/tx_line_packetizer.sv
// tx_line_packetizer: captures RGB444 pixel lines into a ping-pong buffer
// (pixel p -> channel p[1:0], word p>>2) and emits each stored line on four
// links as an address beat followed by LINE_WORDS data beats.
`timescale 1ns/1ps
module tx_line_packetizer #(
  parameter int LINE_WORDS = 80,
  parameter int NUM_LINES  = 480,
  parameter int GAP_CYCLES = 16
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic [11:0] PixData,
  input  logic        PixValid,
  input  logic        PixLineStart,
  input  logic        PixFrameStart,
  input  logic [3:0]  TxReady,
  output logic [47:0] TxData,
  output logic [3:0]  TxValid,
  output logic [63:0] TxAdd,
  output logic [3:0]  TxAddValid,
  output logic        TxBusy,
  output logic [15:0] DropCnt
);

  localparam int AW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int PW = AW + 2;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] LAST_PIX  = PW'(4 * LINE_WORDS - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(LINE_WORDS - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Line storage: [buffer][channel][word]
  logic [11:0]   r_mem [0:1][0:3][0:LINE_WORDS-1];

  // Write-side state
  logic [15:0]   r_line_num;
  logic          r_wr_active;
  logic [PW-1:0] r_pix_cnt;
  logic          r_wr_buf;
  logic [1:0]    r_full;
  logic [15:0]   r_tag [0:1];

  // Read-side state
  state_t        r_state;
  logic          r_rd_buf;
  logic [AW-1:0] r_word_cnt;
  logic [GW-1:0] r_gap_cnt;

  logic          w_line_start;
  logic [15:0]   w_new_line;
  logic [15:0]   w_cur_line;
  logic          w_in_range;
  logic          w_free;
  logic          w_tgt_full;
  logic          w_accept;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_idx;
  logic          w_line_done;
  logic [1:0]    w_drop_inc;
  logic [16:0]   w_drop_sum;
  logic [AW-1:0] w_rd_addr;
  logic [47:0]   w_rd_word;
  logic [15:0]   w_hdr_add;

  assign w_line_start = PixValid & (PixLineStart | PixFrameStart);
  assign w_new_line   = PixFrameStart ? 16'd0 :
                        ((r_line_num == 16'hFFFF) ? 16'hFFFF : r_line_num + 16'd1);
  assign w_cur_line   = w_line_start ? w_new_line : r_line_num;
  assign w_in_range   = (w_new_line < 16'(NUM_LINES));

  // The buffer being drained frees on the last gap cycle; a line starting in
  // that same cycle may claim it.
  assign w_free       = (r_state == S_GAP) && (r_gap_cnt == LAST_GAP);
  assign w_tgt_full   = r_full[r_wr_buf] & ~(w_free & (r_rd_buf == r_wr_buf));
  assign w_accept     = w_line_start & w_in_range & ~w_tgt_full;

  assign w_wr_en      = w_accept | (PixValid & ~w_line_start & r_wr_active);
  assign w_wr_idx     = w_line_start ? '0 : r_pix_cnt;
  assign w_line_done  = w_wr_en & (w_wr_idx == LAST_PIX);

  // A start can abandon a partial line and hit a full buffer at once.
  assign w_drop_inc   = {1'b0, w_line_start & r_wr_active} +
                        {1'b0, w_line_start & w_in_range & w_tgt_full};
  assign w_drop_sum   = {1'b0, DropCnt} + {15'd0, w_drop_inc};

  // Word k+1 is fetched while beat k is on the wire; HDR fetches word 0.
  assign w_rd_addr    = ((r_state == S_DATA) && (r_word_cnt != LAST_WORD)) ?
                        r_word_cnt + AW'(1) : '0;
  assign w_rd_word    = {r_mem[r_rd_buf][3][w_rd_addr], r_mem[r_rd_buf][2][w_rd_addr],
                         r_mem[r_rd_buf][1][w_rd_addr], r_mem[r_rd_buf][0][w_rd_addr]};
  assign w_hdr_add    = 16'(r_tag[r_rd_buf] * 16'(LINE_WORDS));

  // Pixel store into the current write buffer (no reset on storage)
  always_ff @(posedge Cclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_buf][w_wr_idx[1:0]][w_wr_idx[PW-1:2]] <= PixData;
    end
  end

  // Write side: line numbering, capture pointer, full flags and drop counter
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_line_num  <= 16'd0;
      r_wr_active <= 1'b0;
      r_pix_cnt   <= '0;
      r_wr_buf    <= 1'b0;
      r_full      <= 2'b00;
      r_tag[0]    <= 16'd0;
      r_tag[1]    <= 16'd0;
      DropCnt     <= 16'd0;
    end else begin
      DropCnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (w_line_start) begin
        r_line_num  <= w_new_line;
        r_wr_active <= w_accept & ~w_line_done;
        r_pix_cnt   <= PW'(1);
      end else if (w_line_done) begin
        r_wr_active <= 1'b0;
      end else if (w_wr_en) begin
        r_pix_cnt <= r_pix_cnt + PW'(1);
      end
      if (w_line_done) begin
        r_wr_buf        <= ~r_wr_buf;
        r_tag[r_wr_buf] <= w_cur_line;
      end
      for (int b = 0; b < 2; b++) begin
        if (w_line_done && (r_wr_buf == 1'(b))) begin
          r_full[b] <= 1'b1;
        end else if (w_free && (r_rd_buf == 1'(b))) begin
          r_full[b] <= 1'b0;
        end
      end
    end
  end

  // Read FSM: header beat, data beats from the registered read, idle gap
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_rd_buf   <= 1'b0;
      r_word_cnt <= '0;
      r_gap_cnt  <= '0;
      TxData     <= 48'd0;
      TxValid    <= 4'h0;
      TxAdd      <= 64'd0;
      TxAddValid <= 4'h0;
      TxBusy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          TxData  <= 48'd0;
          TxValid <= 4'h0;
          if (r_full[r_rd_buf] && (TxReady == 4'hF)) begin
            r_state    <= S_HDR;
            TxAdd      <= {4{w_hdr_add}};
            TxAddValid <= 4'hF;
            TxBusy     <= 1'b1;
          end else begin
            TxAdd      <= 64'd0;
            TxAddValid <= 4'h0;
            TxBusy     <= 1'b0;
          end
        end
        S_HDR: begin
          TxAdd      <= 64'd0;
          TxAddValid <= 4'h0;
          TxData     <= w_rd_word;
          TxValid    <= 4'hF;
          r_word_cnt <= '0;
          r_state    <= S_DATA;
        end
        S_DATA: begin
          if (r_word_cnt == LAST_WORD) begin
            TxData    <= 48'd0;
            TxValid   <= 4'h0;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else begin
            TxData     <= w_rd_word;
            TxValid    <= 4'hF;
            r_word_cnt <= r_word_cnt + AW'(1);
          end
        end
        S_GAP: begin
          if (r_gap_cnt == LAST_GAP) begin
            r_state  <= S_IDLE;
            r_rd_buf <= ~r_rd_buf;
            TxBusy   <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          TxData     <= 48'd0;
          TxValid    <= 4'h0;
          TxAdd      <= 64'd0;
          TxAddValid <= 4'h0;
          TxBusy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_line_packetizer.sv
// Directed bench for tx_line_packetizer: a table of lines with expected
// packet address and drop count, a packet scoreboard checking every beat,
// and hand-written sequences for back-pressure, line-number limit and reset.
`timescale 1ns/1ps
module tb_tx_line_packetizer;

  localparam int LW  = 80;
  localparam int GAP = 16;

  logic        Cclk = 1'b0;
  logic        rstn;
  logic [11:0] PixData;
  logic        PixValid;
  logic        PixLineStart;
  logic        PixFrameStart;
  logic [3:0]  TxReady;
  logic [47:0] TxData;
  logic [3:0]  TxValid;
  logic [63:0] TxAdd;
  logic [3:0]  TxAddValid;
  logic        TxBusy;
  logic [15:0] DropCnt;

  always #5 Cclk = ~Cclk;

  tx_line_packetizer dut (
    .Cclk(Cclk), .rstn(rstn), .PixData(PixData), .PixValid(PixValid),
    .PixLineStart(PixLineStart), .PixFrameStart(PixFrameStart),
    .TxReady(TxReady), .TxData(TxData), .TxValid(TxValid), .TxAdd(TxAdd),
    .TxAddValid(TxAddValid), .TxBusy(TxBusy), .DropCnt(DropCnt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] add;
    logic [11:0] seed;
  } pkt_t;
  pkt_t exp_q[$];

  typedef struct {
    bit          frame;
    int          npix;
    logic [11:0] seed;
    bit          pkt;
    logic [15:0] add;
    logic [15:0] drop;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] add, input logic [11:0] seed);
    pkt_t e;
    e.add  = add;
    e.seed = seed;
    exp_q.push_back(e);
  endtask

  task automatic drive_line(input bit frame, input int npix, input logic [11:0] seed);
    for (int p = 0; p < npix; p++) begin
      @(negedge Cclk);
      PixValid      = 1'b1;
      PixData       = seed + 12'(p);
      PixLineStart  = (p == 0) && !frame;
      PixFrameStart = (p == 0) && frame;
    end
  endtask

  task automatic idle_pix();
    @(negedge Cclk);
    PixValid      = 1'b0;
    PixData       = 12'd0;
    PixLineStart  = 1'b0;
    PixFrameStart = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || TxBusy) && n < 3000) begin
      @(negedge Cclk);
      n++;
    end
    chk(exp_q.size() == 0 && !TxBusy, "drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(TxData == 48'd0,    {tag, "_txdata"},     64'(TxData),     64'd0);
    chk(TxValid == 4'h0,    {tag, "_txvalid"},    64'(TxValid),    64'd0);
    chk(TxAdd == 64'd0,     {tag, "_txadd"},      TxAdd,           64'd0);
    chk(TxAddValid == 4'h0, {tag, "_txaddvalid"}, 64'(TxAddValid), 64'd0);
    chk(TxBusy == 1'b0,     {tag, "_txbusy"},     64'(TxBusy),     64'd0);
    chk(DropCnt == 16'd0,   {tag, "_dropcnt"},    64'(DropCnt),    64'd0);
  endtask

  // Packet scoreboard: header against queue, data beats, beat count, gap
  int          mon_idle;
  bit          mon_in_data;
  bit          mon_prev_hdr;
  int          mon_beat;
  logic [11:0] mon_seed;
  logic [47:0] mon_ev;
  pkt_t        mon_e;

  always @(negedge Cclk) begin
    if (!rstn) begin
      mon_idle     = 1000;
      mon_in_data  = 1'b0;
      mon_prev_hdr = 1'b0;
      mon_beat     = 0;
    end else begin
      if (mon_prev_hdr) begin
        chk(TxValid == 4'hF, "beat0_after_hdr", 64'(TxValid), 64'hF);
      end
      if (TxAddValid != 4'h0) begin
        chk(TxAddValid == 4'hF, "addvalid_all", 64'(TxAddValid), 64'hF);
        chk(TxValid == 4'h0, "valid_during_hdr", 64'(TxValid), 64'd0);
        chk(mon_idle >= GAP, "gap_before_hdr", 64'(mon_idle), 64'(GAP));
        chk(exp_q.size() != 0, "hdr_expected", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk(TxAdd == {4{mon_e.add}}, "hdr_addr", TxAdd, {4{mon_e.add}});
          mon_seed = mon_e.seed;
        end
        mon_beat     = 0;
        mon_in_data  = 1'b1;
        mon_prev_hdr = 1'b1;
      end else begin
        mon_prev_hdr = 1'b0;
        chk(TxAdd == 64'd0, "add_zero_no_hdr", TxAdd, 64'd0);
        if (TxValid != 4'h0) begin
          chk(mon_in_data, "data_without_hdr", 64'(mon_in_data), 64'd1);
          for (int c = 0; c < 4; c++) begin
            mon_ev[c*12 +: 12] = mon_seed + 12'(4 * mon_beat + c);
          end
          chk(TxValid == 4'hF, "valid_all", 64'(TxValid), 64'hF);
          chk(TxData == mon_ev, "data_beat", 64'(TxData), 64'(mon_ev));
          mon_beat++;
          mon_idle = 0;
        end else begin
          chk(TxData == 48'd0, "data_zero_no_valid", 64'(TxData), 64'd0);
          if (mon_in_data) begin
            chk(mon_beat == LW, "beat_count", 64'(mon_beat), 64'(LW));
          end
          mon_in_data = 1'b0;
          mon_idle++;
        end
      end
    end
  end

  initial begin
    int hdr_seen;
    int n;

    // frame, npix, seed, packet expected, address, DropCnt after line
    tbl[0] = '{1'b1, 320, 12'h000, 1'b1, 16'd0,   16'd0};
    tbl[1] = '{1'b0, 320, 12'h100, 1'b1, 16'd80,  16'd0};
    tbl[2] = '{1'b0, 320, 12'h200, 1'b1, 16'd160, 16'd0};
    tbl[3] = '{1'b0, 100, 12'h300, 1'b0, 16'd0,   16'd0};
    tbl[4] = '{1'b0, 320, 12'h400, 1'b1, 16'd320, 16'd1};
    tbl[5] = '{1'b0, 330, 12'h500, 1'b1, 16'd400, 16'd1};
    tbl[6] = '{1'b0, 320, 12'h600, 1'b1, 16'd480, 16'd1};
    tbl[7] = '{1'b1, 320, 12'hA00, 1'b1, 16'd0,   16'd1};

    rstn          = 1'b0;
    PixData       = 12'd0;
    PixValid      = 1'b0;
    PixLineStart  = 1'b0;
    PixFrameStart = 1'b0;
    TxReady       = 4'hF;
    repeat (3) @(negedge Cclk);
    chk_outputs_zero("reset");
    @(negedge Cclk);
    rstn = 1'b1;

    // Back-to-back lines: normal packets, short line, overlong line
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pkt) push_exp(tbl[i].add, tbl[i].seed);
      drive_line(tbl[i].frame, tbl[i].npix, tbl[i].seed);
      chk(DropCnt == tbl[i].drop, "drop_tbl", 64'(DropCnt), 64'(tbl[i].drop));
    end
    idle_pix();
    wait_drain();

    // Links not ready: two lines buffered, third dropped
    TxReady = 4'h0;
    push_exp(16'd0, 12'hB00);
    push_exp(16'd80, 12'hC00);
    drive_line(1'b1, 320, 12'hB00);
    drive_line(1'b0, 320, 12'hC00);
    drive_line(1'b0, 320, 12'hD00);
    idle_pix();
    chk(DropCnt == 16'd2, "drop_buffers_full", 64'(DropCnt), 64'd2);
    chk(TxBusy == 1'b0, "idle_while_not_ready", 64'(TxBusy), 64'd0);
    repeat (5) @(negedge Cclk);
    TxReady = 4'hF;
    wait_drain();

    // One link not ready: no header until all four are
    TxReady = 4'hE;
    push_exp(16'd0, 12'hE00);
    drive_line(1'b1, 320, 12'hE00);
    idle_pix();
    hdr_seen = 0;
    repeat (50) begin
      @(negedge Cclk);
      if (TxAddValid != 4'h0 || TxBusy) hdr_seen++;
    end
    chk(hdr_seen == 0, "no_hdr_partial_ready", 64'(hdr_seen), 64'd0);
    TxReady = 4'hF;
    @(negedge Cclk);
    chk(TxAddValid == 4'hF, "hdr_after_ready", 64'(TxAddValid), 64'hF);
    chk(TxBusy == 1'b1, "busy_after_ready", 64'(TxBusy), 64'd1);
    wait_drain();

    // Line-number limit: lines 0..478 abandoned after one pixel,
    // line 479 sent at the top address, 480/481 ignored silently
    drive_line(1'b1, 1, 12'h000);
    for (int l = 1; l <= 478; l++) drive_line(1'b0, 1, 12'(l));
    push_exp(16'd38320, 12'h777);
    drive_line(1'b0, 320, 12'h777);
    drive_line(1'b0, 320, 12'h888);
    drive_line(1'b0, 5, 12'h999);
    push_exp(16'd0, 12'hAAA);
    drive_line(1'b1, 320, 12'hAAA);
    idle_pix();
    chk(DropCnt == 16'd481, "drop_line_limit", 64'(DropCnt), 64'd481);
    wait_drain();

    // Reset during data beat 40, then a clean frame
    push_exp(16'd0, 12'h123);
    drive_line(1'b1, 320, 12'h123);
    idle_pix();
    n = 0;
    while (TxAddValid == 4'h0 && n < 2000) begin
      @(negedge Cclk);
      n++;
    end
    chk(TxAddValid == 4'hF, "hdr_before_reset", 64'(TxAddValid), 64'hF);
    repeat (41) @(negedge Cclk);
    chk(TxValid == 4'hF, "beat40_valid", 64'(TxValid), 64'hF);
    #2 rstn = 1'b0;
    #1 chk_outputs_zero("async_reset");
    exp_q.delete();
    repeat (3) @(negedge Cclk);
    rstn = 1'b1;
    push_exp(16'd0, 12'h321);
    drive_line(1'b1, 320, 12'h321);
    idle_pix();
    wait_drain();
    chk(DropCnt == 16'd0, "drop_after_reset", 64'(DropCnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_line_packetizer.md
Name: tx_line_packetizer

Overview:
- Transmit-side counterpart of the 4-link receive memory path.
- Captures an incoming RGB444 pixel line into a ping-pong line buffer. Pixels are split round-robin over 4 channels: channel = pixel index mod 4.
- Emits each line as one packet per link: an address beat carrying the line's word address, then LINE_WORDS data beats.
- The packet format matches what the receive collectors accept on RxData/RxValid/RxAdd/RxAddValid.

Parameters:
- LINE_WORDS, 80, words per channel per line; pixels per line = 4*LINE_WORDS.
- NUM_LINES, 480, lines per frame; lines with index ≥ NUM_LINES are ignored.
- GAP_CYCLES, 16, idle Cclk cycles after each packet before the next header.

Ports:
- Cclk  in  1  system clock; only clock.
- rstn  in  1  asynchronous active-low reset.
- PixData  in  12  pixel {R[3:0],G[3:0],B[3:0]}.
- PixValid  in  1  PixData valid this cycle.
- PixLineStart  in  1  qualified by PixValid: current pixel is pixel 0 of a line.
- PixFrameStart  in  1  qualified by PixValid: current pixel is pixel 0 of line 0; implies line start.
- TxReady  in  4  per-link ready; packet starts only when all 4 are high.
- TxData  out  48  {ch3,ch2,ch1,ch0} 12-bit words.
- TxValid  out  4  data beat per channel.
- TxAdd  out  64  {add3,add2,add1,add0} 16-bit start word address.
- TxAddValid  out  4  address beat per channel.
- TxBusy  out  1  read FSM not IDLE.
- DropCnt  out  16  saturating count of dropped lines.

Behaviour:
- Reset: all outputs 0; both buffers empty; line counter 0; write side waiting for line start; read FSM IDLE.
- Storage: 2 buffers × 4 channels × LINE_WORDS × 12 bit. Pixel p of a line goes to channel p[1:0], word p>>2.
- Write side:
  - Pixels are accepted only after a qualified line start.
  - On a qualified line start: LineNum ← 0 if PixFrameStart, else LineNum+1.
  - Line is ignored (no store, no drop count) if LineNum ≥ NUM_LINES.
  - Pixels beyond 4*LINE_WORDS in a line are discarded.
  - When pixel 4*LINE_WORDS-1 is written: current buffer marked full with tag LineNum; write buffer index toggles.
  - Line start while the target buffer is still full: whole line discarded, DropCnt+1.
  - Line start before the previous line completed: partial line discarded, DropCnt+1; new line captured normally.
  - DropCnt saturates at 16'hFFFF.
- Read FSM, buffers served oldest-first:
  - IDLE: a buffer is full and TxReady==4'hF → HDR.
  - HDR, 1 cycle: TxAddValid=4'hF; each TxAdd lane = tag*LINE_WORDS, 16-bit, max 38320; issue read of word 0.
  - DATA, LINE_WORDS cycles: beat k drives TxValid=4'hF and TxData = word k of each channel. Memory read is registered, so address k+1 is issued while beat k is driven.
  - GAP, GAP_CYCLES cycles: all valids 0; at exit the buffer is marked empty → IDLE.
  - TxReady is sampled only in IDLE; a drop during a packet does not abort it.
- Outputs are registered. TxData/TxAdd are don't-care-free: they read 0 when their valid is low.
- A buffer being read is never written. A buffer freed in the same cycle as a line start can accept that line.
- Reset asserted mid-packet: outputs clear immediately; buffered lines are lost.

Test Plan:
- Frame start + 320 pixels (pixel p = p[11:0]), TxReady=F → one HDR beat TxAdd=0 on all lanes; 80 data beats, beat k ch0=4k, ch3=4k+3; then 16 idle cycles.
- Lines 0..2 back-to-back, no gaps → packets with TxAdd 0, 80, 160 in order; DropCnt=0.
- Hold TxReady=0 while 3 lines arrive → first two buffered, third dropped (DropCnt=1); release → two packets with lines 0,1.
- TxReady=4'hE for 50 cycles after a line completes → no HDR until all ready; HDR on the cycle after TxReady=F is sampled.
- 100-pixel line followed by line start → DropCnt=1, no packet for the short line; next full line sent with TxAdd=(n)*80.
- Assert rstn=0 during DATA beat 40 → all outputs 0 asynchronously; after release, the next frame starts cleanly with TxAdd=0.
